camera_axil_regfile: RTL and testbench
======================================

Name: camera_axil_regfile

Overview:
- Parametrised AXI4-Lite slave register file. Next generation of the camera IP's fixed 4 x 32-bit register slave.
- Adds configurable register count and data width, byte strobes, read-only status registers, SLVERR decode and independent AW/W acceptance.
- Sits between the AXI interconnect and the camera capture/control logic. Exports control registers and a per-register write pulse; imports status words.

Parameters:
C_DATA_WIDTH, 32, AXI data width; 32 or 64.
C_ADDR_WIDTH, 8, AXI byte-address width.
C_NUM_REGS, 8, total registers; power of 2, 2..64.
C_NUM_RO, 2, count of top-index registers that are read-only; 0..C_NUM_REGS-1.

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
AWADDR  in  C_ADDR_WIDTH  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  C_DATA_WIDTH  write data
WSTRB  in  C_DATA_WIDTH/8  byte strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  C_ADDR_WIDTH  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  C_DATA_WIDTH  read data
RRESP  out  2  read response
RVALID  out  1  read valid
RREADY  in  1  read ready
reg_out  out  C_NUM_REGS*C_DATA_WIDTH  flattened register contents; RW slots only, RO slots driven 0
reg_wr_pulse  out  C_NUM_REGS  one-cycle pulse on a successful write to a register
status_in  in  C_NUM_RO*C_DATA_WIDTH  values returned for the RO registers

Behaviour:
- Reset (async, ARESET=1): all RW registers 0; AWREADY=WREADY=ARREADY=1; BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0; reg_wr_pulse=0.
- Decode: LSB = log2(C_DATA_WIDTH/8); index = addr[LSB +: log2(C_NUM_REGS)].
  - Address is out of range if any addr bit above the index field is nonzero.
  - Low byte-offset bits are ignored.
- Write path: AW and W are latched independently.
  - AWREADY drops after its handshake and stays low until the B handshake completes. WREADY behaves the same way.
  - The order of AW and W is free; both in the same cycle is allowed.
- Write FSM states: W_IDLE -> W_COMMIT (both latched) -> W_RESP.
  - W_COMMIT lasts one cycle. Update bytes where WSTRB=1, pulse reg_wr_pulse[index], and go to W_RESP with BVALID=1.
  - Stay in W_RESP until BREADY. Then BVALID=0, AWREADY=WREADY=1, return to W_IDLE.
  - Latency from the later of AW/W handshake to BVALID is 2 cycles.
- BRESP:
  - OKAY (00) for an in-range RW register.
  - SLVERR (10) for an RO or out-of-range target. No register change and no pulse.
  - WSTRB=0 to an RW target gives OKAY, no change, and the pulse still fires.
- Read FSM states: R_IDLE -> R_DATA.
  - On the AR handshake, ARREADY=0 and the next cycle has RVALID=1 with RDATA/RRESP registered.
  - RDATA/RRESP are held stable until RREADY. Then RVALID=0, ARREADY=1.
- Read data:
  - RW register: current contents.
  - RO index k (counted from C_NUM_REGS-C_NUM_RO): status_in slice k, sampled at the AR handshake edge.
  - Out of range: RDATA=0, RRESP=SLVERR.
- Simultaneous read and write commit to the same register: the read samples the pre-commit value.
- Read and write channels run fully concurrently.
- ARESET mid-transaction: all state returns to reset values immediately. Outstanding responses are dropped.

Optional Feature:
- Macro CAMERA_AXIL_W1C_EN adds port irq (out, 1) and makes register 0 a write-one-to-clear interrupt status register.
  - irq_set_in (in, C_DATA_WIDTH) is ORed into reg0 each cycle.
  - A write clears bits where WDATA=1 under strobe.
  - If set and clear hit the same bit in the same cycle, the bit stays set.
  - irq = |reg0, registered.
- Without the macro: no irq or irq_set_in ports, and register 0 is a plain RW register.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, then read back -> data matches, all BRESP/RRESP=00, reg_wr_pulse pulses bits 0..3 once each.
- Write 0xAABBCCDD to 0x4 with WSTRB=4'b0101 over a prior value of 0 -> readback 0x00BB00DD.
- W presented 3 cycles before AW at 0x8 -> single commit, BVALID 2 cycles after the AW handshake, AWREADY/WREADY low until BREADY.
- status_in top word 0xCAFE0001, read 0x1C (C_NUM_REGS=8) -> RDATA=0xCAFE0001, OKAY. Write 0x1C -> SLVERR, and a readback still returns status_in.
- Read 0x20 and write 0x40 (out of range) -> RRESP=10 with RDATA=0, BRESP=10, no pulse. BREADY held low 5 cycles -> BVALID/BRESP stable throughout.
- Assert ARESET while BVALID=1 -> BVALID=0 and all registers 0 in the same cycle (async). After release the next write completes normally.

Source files
------------

// File: rtl/camera_axil_if.sv
// AXI4-Lite bus bundle for camera_axil_regfile: AW/W/B/AR/R channels with master and slave views.
interface camera_axil_if #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 8
);
  logic [C_ADDR_WIDTH-1:0]   AWADDR;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [C_DATA_WIDTH-1:0]   WDATA;
  logic [C_DATA_WIDTH/8-1:0] WSTRB;
  logic                      WVALID;
  logic                      WREADY;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;
  logic [C_ADDR_WIDTH-1:0]   ARADDR;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [C_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/camera_axil_regfile.sv
// Parametrised AXI4-Lite register file: RW control words, top-index RO status words, per-register write pulses.
// Optional define CAMERA_AXIL_W1C_EN makes register 0 a write-one-to-clear interrupt status word driving irq.
module camera_axil_regfile #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 8,
  parameter int C_NUM_REGS   = 8,
  parameter int C_NUM_RO     = 2
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  camera_axil_if.slave                         s_axi,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0]   reg_out,
  output logic [C_NUM_REGS-1:0]                reg_wr_pulse,
  input  logic [((C_NUM_RO > 0) ? C_NUM_RO : 1)*C_DATA_WIDTH-1:0] status_in
`ifdef CAMERA_AXIL_W1C_EN
  ,
  input  logic [C_DATA_WIDTH-1:0]              irq_set_in,
  output logic                                 irq
`endif
);
  localparam int STRB_W  = C_DATA_WIDTH / 8;
  localparam int LSB     = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(C_NUM_REGS);
  localparam int HI_W    = C_ADDR_WIDTH - LSB;
  localparam int RO_BASE = C_NUM_REGS - C_NUM_RO;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_COMMIT = 2'd1;
  localparam logic [1:0] W_RESP   = 2'd2;
  localparam logic [0:0] R_IDLE   = 1'b0;
  localparam logic [0:0] R_DATA   = 1'b1;

  typedef logic [C_DATA_WIDTH-1:0] word_t;

  // Addresses are kept without their byte-offset bits; index sits at the bottom.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [HI_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  function automatic logic addr_oor(input logic [HI_W-1:0] a);
    return (a >> IDX_W) != '0;
  endfunction

  function automatic logic idx_is_ro(input logic [IDX_W-1:0] i);
    return int'(i) >= RO_BASE;
  endfunction

  word_t              regs_q [C_NUM_REGS];
  word_t              regs_d [C_NUM_REGS];
  word_t              rd_word [C_NUM_REGS];

  logic [1:0]         wstate_q, wstate_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic [HI_W-1:0]    awaddr_q, awaddr_d;
  word_t              wdata_q, wdata_d;
  logic [STRB_W-1:0]  wstrb_q, wstrb_d;
  logic [1:0]         bresp_q, bresp_d;
  logic [C_NUM_REGS-1:0] pulse_q, pulse_d;

  logic [0:0]         rstate_q, rstate_d;
  word_t              rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;

  logic [IDX_W-1:0]   w_idx;
  logic               commit_ok;
  logic               commit_now;
  word_t              wmask;
  logic [HI_W-1:0]    ar_hi;
  logic               unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi.AWADDR[LSB-1:0], s_axi.ARADDR[LSB-1:0]};

  assign w_idx      = addr_idx(awaddr_q);
  assign commit_ok  = !addr_oor(awaddr_q) && !idx_is_ro(w_idx);
  assign commit_now = (wstate_q == W_COMMIT) && commit_ok;
  assign ar_hi      = s_axi.ARADDR[C_ADDR_WIDTH-1:LSB];

  always_comb begin
    wmask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      wmask[8*b +: 8] = {8{wstrb_q[b]}};
    end
  end

  assign s_axi.AWREADY = (wstate_q == W_IDLE) && !aw_done_q;
  assign s_axi.WREADY  = (wstate_q == W_IDLE) && !w_done_q;
  assign s_axi.BVALID  = (wstate_q == W_RESP);
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = (rstate_q == R_IDLE);
  assign s_axi.RVALID  = (rstate_q == R_DATA);
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = rresp_q;
  assign reg_wr_pulse  = pulse_q;

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_slot
    if (i < RO_BASE) begin : g_rw
      assign rd_word[i] = regs_q[i];
      assign reg_out[i*C_DATA_WIDTH +: C_DATA_WIDTH] = regs_q[i];
    end else begin : g_ro
      assign rd_word[i] = status_in[(i-RO_BASE)*C_DATA_WIDTH +: C_DATA_WIDTH];
      assign reg_out[i*C_DATA_WIDTH +: C_DATA_WIDTH] = '0;
    end
  end

  // AW and W latch independently; the commit fires once both are held.
  always_comb begin
    wstate_d  = wstate_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    pulse_d   = '0;
    case (wstate_q)
      W_IDLE: begin
        if (s_axi.AWVALID && s_axi.AWREADY) begin
          aw_done_d = 1'b1;
          awaddr_d  = s_axi.AWADDR[C_ADDR_WIDTH-1:LSB];
        end
        if (s_axi.WVALID && s_axi.WREADY) begin
          w_done_d = 1'b1;
          wdata_d  = s_axi.WDATA;
          wstrb_d  = s_axi.WSTRB;
        end
        if (aw_done_d && w_done_d) wstate_d = W_COMMIT;
      end
      W_COMMIT: begin
        wstate_d       = W_RESP;
        bresp_d        = commit_ok ? RESP_OKAY : RESP_SLVERR;
        pulse_d[w_idx] = commit_ok;
      end
      W_RESP: begin
        if (s_axi.BREADY) begin
          wstate_d  = W_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (commit_now) begin
      regs_d[w_idx] = (regs_q[w_idx] & ~wmask) | (wdata_q & wmask);
    end
`ifdef CAMERA_AXIL_W1C_EN
    // Set sources win over a same-cycle clear.
    regs_d[0] = (regs_q[0] & ~((commit_now && (w_idx == '0)) ? (wdata_q & wmask) : '0))
                | irq_set_in;
`endif
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rstate_q == R_IDLE) begin
      if (s_axi.ARVALID) begin
        rstate_d = R_DATA;
        if (addr_oor(ar_hi)) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end else begin
          rdata_d = rd_word[addr_idx(ar_hi)];
          rresp_d = RESP_OKAY;
        end
      end
    end else if (s_axi.RREADY) begin
      rstate_d = R_IDLE;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      rstate_q  <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      for (int i = 0; i < C_NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wstate_q  <= wstate_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      pulse_q   <= pulse_d;
      rstate_q  <= rstate_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

`ifdef CAMERA_AXIL_W1C_EN
  logic irq_q, irq_d;
  assign irq_d = |regs_d[0];
  assign irq   = irq_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end
`endif
endmodule

// File: tb/tb_camera_axil_regfile.sv
// Directed bench for camera_axil_regfile (32-bit data, 8 registers, top 2 read-only).
module tb_camera_axil_regfile;
  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [255:0] reg_out;
  logic [7:0]   reg_wr_pulse;
  logic [63:0]  status_in;
`ifdef CAMERA_AXIL_W1C_EN
  logic [31:0]  irq_set_in = '0;
  logic         irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt [8] = '{default: 0};
  int pulse_total = 0;

  camera_axil_if #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(8)) bus ();

  camera_axil_regfile #(
    .C_DATA_WIDTH(32), .C_ADDR_WIDTH(8), .C_NUM_REGS(8), .C_NUM_RO(2)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .s_axi        (bus),
    .reg_out      (reg_out),
    .reg_wr_pulse (reg_wr_pulse),
    .status_in    (status_in)
`ifdef CAMERA_AXIL_W1C_EN
    ,
    .irq_set_in   (irq_set_in),
    .irq          (irq)
`endif
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) begin
    if (!ARESET) begin
      for (int i = 0; i < 8; i++) begin
        if (reg_wr_pulse[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
      end
      pulse_total <= pulse_total + $countones(reg_wr_pulse);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int  t = 0;
    logic aw_hs, w_hs;
    @(negedge ACLK);
    bus.AWADDR = a; bus.AWVALID = 1'b1;
    bus.WDATA = d;  bus.WSTRB = s; bus.WVALID = 1'b1;
    bus.BREADY = 1'b1;
    while ((bus.AWVALID || bus.WVALID) && t < 20) begin
      aw_hs = bus.AWVALID && bus.AWREADY;
      w_hs  = bus.WVALID && bus.WREADY;
      @(negedge ACLK); t++;
      if (aw_hs) bus.AWVALID = 1'b0;
      if (w_hs)  bus.WVALID  = 1'b0;
    end
    while (!bus.BVALID && t < 20) begin
      @(negedge ACLK); t++;
    end
    if (t >= 20) check_eq("wr_timeout", 1, 0);
    resp = bus.BRESP;
    @(negedge ACLK);
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int t = 0;
    @(negedge ACLK);
    bus.ARADDR = a; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    while (!bus.ARREADY && t < 20) begin
      @(negedge ACLK); t++;
    end
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    while (!bus.RVALID && t < 20) begin
      @(negedge ACLK); t++;
    end
    if (t >= 20) check_eq("rd_timeout", 1, 0);
    d = bus.RDATA;
    resp = bus.RRESP;
    @(negedge ACLK);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          t;
    int          p0;

    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    status_in = {32'hCAFE0001, 32'h12345678};

    repeat (3) @(negedge ACLK);
    check_eq("rst_awready", bus.AWREADY, 1);
    check_eq("rst_wready",  bus.WREADY, 1);
    check_eq("rst_arready", bus.ARREADY, 1);
    check_eq("rst_bvalid",  bus.BVALID, 0);
    check_eq("rst_rvalid",  bus.RVALID, 0);
    check_eq("rst_rdata",   bus.RDATA, 0);
    check_eq("rst_regs",    (reg_out != 0), 0);
    check_eq("rst_pulse",   reg_wr_pulse, 0);
    ARESET = 1'b0;

    // Basic writes and readback
    for (int i = 0; i < 4; i++) begin
      axi_write(8'(4*i), 32'(i+1), 4'hF, resp);
      check_eq("wr_bresp", resp, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(8'(4*i), rd, resp);
      check_eq("rd_data", rd, 32'(i+1));
      check_eq("rd_rresp", resp, 2'b00);
    end
    for (int i = 0; i < 8; i++) check_eq("pulse_once", pulse_cnt[i], (i < 4) ? 1 : 0);
    check_eq("reg_out_r3", reg_out[3*32 +: 32], 32'h4);

    // Byte strobes
    axi_write(8'h04, 32'h0, 4'hF, resp);
    axi_write(8'h04, 32'hAABBCCDD, 4'b0101, resp);
    check_eq("strb_bresp", resp, 2'b00);
    axi_read(8'h04, rd, resp);
    check_eq("strb_data", rd, 32'h00BB00DD);

    // Zero strobe: OKAY, no change, pulse still fires
    axi_write(8'h10, 32'hFFFFFFFF, 4'h0, resp);
    check_eq("strb0_bresp", resp, 2'b00);
    axi_read(8'h10, rd, resp);
    check_eq("strb0_data", rd, 32'h0);
    check_eq("strb0_pulse", pulse_cnt[4], 1);

    // W three cycles ahead of AW
    @(negedge ACLK);
    bus.BREADY = 1'b0; bus.WDATA = 32'h55; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(negedge ACLK);
    bus.WVALID = 1'b0;
    check_eq("wfirst_wready_low", bus.WREADY, 0);
    check_eq("wfirst_awready_hi", bus.AWREADY, 1);
    @(negedge ACLK);
    check_eq("wfirst_no_bvalid", bus.BVALID, 0);
    @(negedge ACLK);
    bus.AWADDR = 8'h08; bus.AWVALID = 1'b1;
    @(negedge ACLK);
    bus.AWVALID = 1'b0;
    check_eq("wfirst_commit_cyc", bus.BVALID, 0);
    @(negedge ACLK);
    check_eq("wfirst_bvalid_lat2", bus.BVALID, 1);
    check_eq("wfirst_bresp", bus.BRESP, 2'b00);
    check_eq("wfirst_awready_low", bus.AWREADY, 0);
    check_eq("wfirst_wready_low2", bus.WREADY, 0);
    @(negedge ACLK);
    check_eq("wfirst_bvalid_hold", bus.BVALID, 1);
    check_eq("wfirst_awready_hold", bus.AWREADY, 0);
    bus.BREADY = 1'b1;
    @(negedge ACLK);
    check_eq("wfirst_bvalid_done", bus.BVALID, 0);
    check_eq("wfirst_awready_back", bus.AWREADY, 1);
    check_eq("wfirst_wready_back", bus.WREADY, 1);
    axi_read(8'h08, rd, resp);
    check_eq("wfirst_data", rd, 32'h55);
    check_eq("wfirst_pulse", pulse_cnt[2], 2);

    // Read-only status words
    axi_read(8'h1C, rd, resp);
    check_eq("ro_data", rd, 32'hCAFE0001);
    check_eq("ro_rresp", resp, 2'b00);
    axi_read(8'h18, rd, resp);
    check_eq("ro_data6", rd, 32'h12345678);
    axi_write(8'h1C, 32'h11111111, 4'hF, resp);
    check_eq("ro_wr_bresp", resp, 2'b10);
    axi_read(8'h1C, rd, resp);
    check_eq("ro_data_after_wr", rd, 32'hCAFE0001);
    check_eq("ro_pulse", pulse_cnt[7], 0);
    check_eq("ro_reg_out_zero", reg_out[7*32 +: 32], 32'h0);

    // Out-of-range read and write with delayed BREADY
    axi_read(8'h20, rd, resp);
    check_eq("oor_rresp", resp, 2'b10);
    check_eq("oor_rdata", rd, 32'h0);
    p0 = pulse_total;
    @(negedge ACLK);
    bus.AWADDR = 8'h40; bus.AWVALID = 1'b1; bus.WDATA = 32'hDEAD; bus.WSTRB = 4'hF;
    bus.WVALID = 1'b1; bus.BREADY = 1'b0;
    @(negedge ACLK);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    t = 0;
    while (!bus.BVALID && t < 10) begin
      @(negedge ACLK); t++;
    end
    check_eq("oor_bvalid_seen", bus.BVALID, 1);
    for (int k = 0; k < 5; k++) begin
      check_eq("oor_bvalid_hold", bus.BVALID, 1);
      check_eq("oor_bresp_hold", bus.BRESP, 2'b10);
      @(negedge ACLK);
    end
    bus.BREADY = 1'b1;
    @(negedge ACLK);
    check_eq("oor_bvalid_done", bus.BVALID, 0);
    @(negedge ACLK);
    check_eq("oor_no_pulse", pulse_total, p0);

    // Async reset with a response outstanding
    @(negedge ACLK);
    bus.AWADDR = 8'h00; bus.AWVALID = 1'b1; bus.WDATA = 32'h99; bus.WSTRB = 4'hF;
    bus.WVALID = 1'b1; bus.BREADY = 1'b0;
    @(negedge ACLK);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    check_eq("arst_pre_bvalid", bus.BVALID, 1);
    check_eq("arst_pre_regs_nz", (reg_out != 0), 1);
    #2 ARESET = 1'b1;
    #1;
    check_eq("arst_bvalid", bus.BVALID, 0);
    check_eq("arst_regs", (reg_out != 0), 0);
    check_eq("arst_awready", bus.AWREADY, 1);
    check_eq("arst_wready", bus.WREADY, 1);
    @(negedge ACLK);
    ARESET = 1'b0;
    bus.BREADY = 1'b1;
    axi_write(8'h0C, 32'h7, 4'hF, resp);
    check_eq("post_rst_bresp", resp, 2'b00);
    axi_read(8'h0C, rd, resp);
    check_eq("post_rst_data", rd, 32'h7);
    axi_read(8'h00, rd, resp);
    check_eq("post_rst_r0", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
